// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci-class sequence generator.
package fib_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Reset-time seeds give the classic Fibonacci stream
  localparam int unsigned FIB_SEED0 = 0;
  localparam int unsigned FIB_SEED1 = 1;

endpackage

// File: rtl/fib_seq_step.sv
// Recurrence step: (WIDTH+1)-bit sum of two terms, split into truncated sum and carry.
module fib_seq_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_c_o,
  output logic             carry_c_o
);

  logic [WIDTH:0] full_c;

  assign full_c    = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i);
  assign sum_c_o   = full_c[WIDTH-1:0];
  assign carry_c_o = full_c[WIDTH];

endmodule

// File: rtl/fib_seq_gen.sv
// Seedable Fibonacci-class stream source with valid/ready output and overflow detection.
// Define FIB_SEQ_WRAP_EN to let the stream continue modulo 2**WIDTH instead of stopping.
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             ovf,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic             nxt_bad_q, nxt_bad_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic             accept_c;

  fib_seq_step #(.WIDTH(WIDTH)) u_step (
    .a_i      (cur_q),
    .b_i      (nxt_q),
    .sum_c_o  (sum_c),
    .carry_c_o(carry_c)
  );

  assign accept_c = valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= WIDTH'(FIB_SEED0);
      nxt_q     <= WIDTH'(FIB_SEED1);
      nxt_bad_q <= 1'b0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      nxt_bad_q <= nxt_bad_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Next-state: load overrides everything; an accepted term shifts the window by one
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    nxt_bad_d = nxt_bad_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    done_d    = done_q;

    if (load) begin
      state_d   = IDLE;
      cur_d     = seed0;
      nxt_d     = seed1;
      nxt_bad_d = 1'b0;
      idx_d     = '0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = VALID;
            valid_d = 1'b1;
          end
        end
        VALID: begin
          if (accept_c) begin
`ifdef FIB_SEQ_WRAP_EN
            cur_d     = nxt_q;
            nxt_d     = sum_c;
            nxt_bad_d = carry_c;
            idx_d     = idx_q + IDX_W'(1);
            if (nxt_bad_q) ovf_d = 1'b1;
            if (!en) begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
`else
            if (nxt_bad_q) begin
              // Next term would not fit: end the stream after the last exact term
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
              ovf_d   = 1'b1;
            end else begin
              cur_d     = nxt_q;
              nxt_d     = sum_c;
              nxt_bad_d = carry_c;
              idx_d     = idx_q + IDX_W'(1);
              if (!en) begin
                state_d = IDLE;
                valid_d = 1'b0;
              end
            end
`endif
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = cur_q;
  assign out_idx   = idx_q;
  assign ovf       = ovf_q;
  assign done      = done_q;

endmodule
